alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (requester 0 and requester 1) in round-robin order. Each request carries operands and an ALU operation. The request is latched, executed on the shared ALU, and the result is returned on the winner's response channel with a valid/ready handshake. The block sits between issuing units and the ALU datapath and is the only driver of the ALU's inputs.

## Interface
Parameters:
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid0 / req_valid1  in  1  request present from requester 0 / 1
- req_ready0 / req_ready1  out  1  request accepted this cycle
- req_A0, req_B0 / req_A1, req_B1  in  WIDTH  operands
- req_op0 / req_op1  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra
- resp_valid0 / resp_valid1  out  1  result available for requester 0 / 1
- resp_ready0 / resp_ready1  in  1  requester takes the result
- resp_C  out  WIDTH  result, shared by both response channels
- resp_err  out  1  illegal op flag; present only with ALU_ARB_ILLEGAL_OP_EN

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no valid request: stay.
  - Else choose the winner. Only one valid: it wins. Both valid: the requester not granted last wins (pointer `last`).
  - Assert req_ready for the winner only, combinationally, in the same cycle.
  - On the edge: latch A, B and op into A_r, B_r, op_r; record the winner in gnt; go to EXEC.
- EXEC:
  - ALU inputs are A_r, B_r, op_r.
  - Capture ALU output into C_r; go to RESP.
- RESP:
  - resp_valid[gnt] = 1; resp_C = C_r.
  - On resp_ready[gnt]: set last ← gnt and go to IDLE. Otherwise hold every output stable.
- req_ready is 0 in EXEC and RESP. New requests wait and are never dropped.
- Arithmetic:
  - Add and sub are modulo 2^WIDTH, with no carry or overflow output.
  - Shifts use the full B value as the shift amount. B ≥ WIDTH gives 0 for srl and all-sign-bits for sra.
- Ops 110 and 111 produce C_r = 0.
- resp_valid on the non-granted channel is always 0. resp_ready on that channel is ignored.

## Timing
- Reset values:
  - state = IDLE, last = 1 (requester 0 wins the first tie), gnt = 0.
  - A_r, B_r, op_r and C_r = 0.
  - All req_ready and resp_valid = 0; resp_C = 0; resp_err = 0.
- Latency: request accepted at edge t → resp_valid rises after edge t+1 (visible cycle t+2 relative to the accept cycle).
- Best-case throughput is one operation per 3 cycles, when resp_ready is held high.
- Simultaneous valid requests in IDLE: exactly one req_ready is asserted. The loser is served next if it is still valid.
- A requester that deasserts valid before being granted is simply skipped, with no penalty.
- Reset asserted mid-operation (EXEC or RESP) immediately forces reset values. The in-flight result is discarded and no response is produced.
- resp_C reflects C_r in all states. Consumers must qualify it with resp_valid.

## Configuration
- ALU_ARB_ILLEGAL_OP_EN defined:
  - Adds the resp_err output and a registered err_r bit, which is set in EXEC when op_r ∈ {110, 111}.
  - resp_err = err_r while in RESP, 0 otherwise.
- Undefined: no resp_err port exists. Illegal ops still return 0 silently.

## Structure
- Shared package holds:
  - WIDTH default
  - ALU op encodings (ALU_ADD … ALU_SRA)
  - FSM state encodings (IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2)
- One sub-module: the existing combinational alu (ports A, B, ALUOp, C), instantiated once and fed from A_r/B_r/op_r.
- The block adds the default-to-zero handling for ops 110 and 111 around the ALU output.
- The arbitration, FSM and registers live in alu_arbiter.

## Test plan
- Single request: req0 add A = 5, B = 7, resp_ready0 = 1 → req_ready0 high in the accept cycle; resp_valid0 two cycles later with resp_C = 12; resp_valid1 stays 0.
- Tie after reset: both valid (req0 sub 3−5, req1 or 0xF0|0x0F) → req0 first, resp_C = 0xFFFFFFFE; then req1, resp_C = 0x000000FF.
- Fairness: both held valid for 6 operations → grants alternate 0, 1, 0, 1, 0, 1.
- Backpressure: resp_ready1 held low 4 cycles → resp_valid1 and resp_C stable; req_ready0 stays 0 though req_valid0 = 1; req0 is accepted the cycle after IDLE is re-entered.
- Shifts: sra A = 0x80000000, B = 4 → 0xF8000000. srl same operands → 0x08000000. sra A = 0x80000000, B = 40 → 0xFFFFFFFF.
- Reset mid-EXEC: assert reset in EXEC → all outputs 0 immediately; no resp_valid after release. With ALU_ARB_ILLEGAL_OP_EN, op 111 → resp_C = 0, resp_err = 1 in RESP.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width default, ALU op encodings, FSM state
// encodings and the illegal-op helper for the alu_arbiter block.
package alu_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Encodings 110 and 111 have no ALU function and return zero
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: the shared combinational 32-bit ALU. Shifts take the full
// B operand as the shift amount, so B >= WIDTH shifts everything out.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C
);

  // Operation select; add/sub wrap modulo 2^WIDTH
  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> B;
      ALU_SRA: C = $signed(A) >>> B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters.
// IDLE accepts one request, EXEC evaluates it, RESP presents the result
// until the granted requester takes it.
// Optional feature: define ALU_ARB_ILLEGAL_OP_EN to add the resp_err output.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_A0,
  input  logic [WIDTH-1:0] req_B0,
  input  logic [WIDTH-1:0] req_A1,
  input  logic [WIDTH-1:0] req_B1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_C
`ifdef ALU_ARB_ILLEGAL_OP_EN
  ,
  output logic             resp_err
`endif
);

  state_e           r_state;
  logic             r_last;
  logic             r_gnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_c;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic             r_err;
`endif

  logic             w_any;
  logic             w_win;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_alu_c;
  logic [WIDTH-1:0] w_c;
  logic             w_resp_take;

  // Winner selection: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_any = req_valid0 | req_valid1;
    if (req_valid0 && req_valid1) begin
      w_win = ~r_last;
    end else begin
      w_win = req_valid1;
    end
    w_a  = w_win ? req_A1  : req_A0;
    w_b  = w_win ? req_B1  : req_B0;
    w_op = w_win ? req_op1 : req_op0;
  end

  assign req_ready0 = ~reset && (r_state == IDLE) && w_any && ~w_win;
  assign req_ready1 = ~reset && (r_state == IDLE) && w_any &&  w_win;

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .A     (r_a),
    .B     (r_b),
    .ALUOp (r_op),
    .C     (w_alu_c)
  );

  assign w_c         = op_is_illegal(r_op) ? '0 : w_alu_c;
  assign w_resp_take = r_gnt ? resp_ready1 : resp_ready0;

  // Control FSM plus operand/result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_c     <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_gnt   <= w_win;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_c     <= w_c;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          r_err   <= op_is_illegal(r_op);
`endif
          r_state <= RESP;
        end
        RESP: begin
          if (w_resp_take) begin
            r_last  <= r_gnt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid0 = (r_state == RESP) && ~r_gnt;
  assign resp_valid1 = (r_state == RESP) &&  r_gnt;
  assign resp_C      = r_c;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign resp_err    = (r_state == RESP) && r_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with hand-computed results.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_A0, req_B0, req_A1, req_B1;
  logic [2:0]  req_op0, req_op1;
  logic        resp_valid0, resp_valid1;
  logic        resp_ready0, resp_ready1;
  logic [31:0] resp_C;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic        resp_err;
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid0  (req_valid0),
    .req_valid1  (req_valid1),
    .req_ready0  (req_ready0),
    .req_ready1  (req_ready1),
    .req_A0      (req_A0),
    .req_B0      (req_B0),
    .req_A1      (req_A1),
    .req_B1      (req_B1),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .resp_valid0 (resp_valid0),
    .resp_valid1 (resp_valid1),
    .resp_ready0 (resp_ready0),
    .resp_ready1 (resp_ready1),
    .resp_C      (resp_C)
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    .resp_err    (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with inputs already set; resp_ready of winner high
  task automatic serve(input string tag, input logic g, input logic [31:0] c, input logic e);
    #1;
    chk({tag, "_rdy_win"},  g ? req_ready1 : req_ready0, 32'd1);
    chk({tag, "_rdy_lose"}, g ? req_ready0 : req_ready1, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_exec_rv"},  {31'd0, resp_valid0 | resp_valid1}, 32'd0);
    chk({tag, "_exec_rdy"}, {31'd0, req_ready0 | req_ready1}, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_rv_win"},  g ? resp_valid1 : resp_valid0, 32'd1);
    chk({tag, "_rv_lose"}, g ? resp_valid0 : resp_valid1, 32'd0);
    chk({tag, "_C"}, resp_C, c);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e});
`else
    if (e) chk({tag, "_noerr_C"}, resp_C, 32'd0);
`endif
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid0 = v; req_op0 = op; req_A0 = a; req_B0 = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid1 = v; req_op1 = op; req_A1 = a; req_B1 = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set0(1'b1, 3'b000, 32'd1, 32'd1);
    set1(1'b0, 3'b000, 32'd0, 32'd0);
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;

    // Reset state, with a valid request pending
    @(negedge clk); #1;
    chk("rst_rdy0", {31'd0, req_ready0}, 32'd0);
    chk("rst_rdy1", {31'd0, req_ready1}, 32'd0);
    chk("rst_rv0",  {31'd0, resp_valid0}, 32'd0);
    chk("rst_rv1",  {31'd0, resp_valid1}, 32'd0);
    chk("rst_C",    resp_C, 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("rst_err",  {31'd0, resp_err}, 32'd0);
`endif
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request: 5 + 7
    resp_ready0 = 1'b1;
    resp_ready1 = 1'b1;
    set0(1'b1, 3'b000, 32'd5, 32'd7);
    serve("add", 1'b0, 32'd12, 1'b0);
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk("idle_rv0", {31'd0, resp_valid0}, 32'd0);

    // Tie right after reset: requester 0 first, then 1
    do_reset();
    set0(1'b1, 3'b001, 32'd3, 32'd5);
    set1(1'b1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    serve("tie0", 1'b0, 32'hFFFF_FFFE, 1'b0);
    serve("tie1", 1'b1, 32'h0000_00FF, 1'b0);

    // Fairness: both held valid, grants alternate
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) serve("fair0", 1'b0, 32'hFFFF_FFFE, 1'b0);
      else            serve("fair1", 1'b1, 32'h0000_00FF, 1'b0);
    end

    // Backpressure on requester 1 while requester 0 waits
    set0(1'b0, 3'b010, 32'h0000_00FF, 32'h0000_000F);
    set1(1'b1, 3'b000, 32'd1, 32'd2);
    resp_ready1 = 1'b0;
    #1;
    chk("bp_rdy1", {31'd0, req_ready1}, 32'd1);
    @(negedge clk);
    req_valid0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rv1",   {31'd0, resp_valid1}, 32'd1);
      chk("bp_rv0",   {31'd0, resp_valid0}, 32'd0);
      chk("bp_C",     resp_C, 32'd3);
      chk("bp_rdy0",  {31'd0, req_ready0}, 32'd0);
      if (i == 3) begin
        resp_ready1 = 1'b1;
        req_valid1  = 1'b0;
      end
      @(negedge clk);
    end
    serve("bp_next0", 1'b0, 32'h0000_000F, 1'b0);

    // Shifts, including shift amounts past the width
    set0(1'b1, 3'b101, 32'h8000_0000, 32'd4);
    serve("sra4", 1'b0, 32'hF800_0000, 1'b0);
    set0(1'b1, 3'b100, 32'h8000_0000, 32'd4);
    serve("srl4", 1'b0, 32'h0800_0000, 1'b0);
    set0(1'b1, 3'b100, 32'h8000_0000, 32'd40);
    serve("srl40", 1'b0, 32'h0000_0000, 1'b0);
    set0(1'b1, 3'b101, 32'h8000_0000, 32'd40);
    serve("sra40", 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Illegal ops return zero
    set0(1'b1, 3'b111, 32'd5, 32'd7);
    serve("op111", 1'b0, 32'd0, 1'b1);
    set0(1'b1, 3'b000, 32'd9, 32'd9);
    serve("add18", 1'b0, 32'd18, 1'b0);
    set0(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1);
    serve("op110", 1'b0, 32'd0, 1'b1);

    // Reset in EXEC discards the in-flight operation
    set0(1'b1, 3'b000, 32'd5, 32'd7);
    #1;
    chk("rx_rdy0", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    chk("rx_rv0", {31'd0, resp_valid0}, 32'd0);
    chk("rx_C",   resp_C, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rx_after_rv", {30'd0, resp_valid1, resp_valid0}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
